// File: rtl/bp_pkg.sv
// bp_pkg: shared defaults, FSM state type and trace entry layout {id, outcome}
package bp_pkg;
  localparam int ID_W_DEF = 3;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  function automatic int entry_w(input int id_w);
    return id_w + 1;
  endfunction
endpackage

// File: rtl/branch_trace_mem.sv
// branch_trace_mem: trace storage, synchronous write, asynchronous read, no reset
module branch_trace_mem #(
  parameter int W = 4,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/branch_trace_driver.sv
// branch_trace_driver: replays a stored branch trace into a predictor and scores its misses
module branch_trace_driver
  import bp_pkg::*;
#(
  parameter int ID_W = ID_W_DEF,
  parameter int DEPTH = 256,
  parameter int ADDR_W = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [ID_W-1:0]   load_id,
  input  logic              load_outcome,
  input  logic [ADDR_W:0]   trace_len,
  input  logic              start,
  output logic              br_valid,
  output logic [ID_W-1:0]   br_id,
  output logic              br_outcome,
  input  logic              miss,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total_count,
  output logic [CNT_W-1:0]  miss_count,
  input  logic [ID_W-1:0]   stat_sel,
  output logic [CNT_W-1:0]  stat_miss
);
  localparam int EW = entry_w(ID_W);
  state_t state;
  logic [ADDR_W:0] ptr, len;
  logic v1;
  logic [ID_W-1:0] id1;
  logic [CNT_W-1:0] per_id [2**ID_W];
  logic [EW-1:0] rd;
  logic idle, go;
  assign idle = state == IDLE;
  assign go = idle && start;
  function automatic logic [CNT_W-1:0] inc(input logic [CNT_W-1:0] c);
    return c + CNT_W'(c != '1);
  endfunction
  branch_trace_mem #(.W(EW), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk(clk),
    .we(load_en && idle && !reset),
    .waddr(load_addr),
    .wdata({load_id, load_outcome}),
    .raddr(idle ? '0 : ptr[ADDR_W-1:0]),
    .rdata(rd)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      br_valid <= 1'b0;
      br_id <= '0;
      br_outcome <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      stat_miss <= '0;
      ptr <= '0;
      len <= '0;
      v1 <= 1'b0;
      id1 <= '0;
    end else begin
      v1 <= br_valid;
      id1 <= br_id;
      stat_miss <= per_id[stat_sel];
      done <= state == DRAIN || (go && trace_len == '0);
      case (state)
        IDLE: if (go && trace_len != '0) begin
          len <= trace_len;
          {br_id, br_outcome} <= rd;
          ptr <= (ADDR_W+1)'(1);
          br_valid <= 1'b1;
          busy <= 1'b1;
          state <= RUN;
        end
        RUN: if (ptr < len) begin
          {br_id, br_outcome} <= rd;
          ptr <= ptr + 1'b1;
        end else begin
          br_valid <= 1'b0;
          state <= DRAIN;
        end
        DRAIN: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  // v1/id1 delay the presented event by one edge so it lines up with the registered miss
  always_ff @(posedge clk)
    if (reset || go) begin
      total_count <= '0;
      miss_count <= '0;
      for (int i = 0; i < 2**ID_W; i++) per_id[i] <= '0;
    end else if (v1) begin
      total_count <= inc(total_count);
      if (miss) begin
        miss_count <= inc(miss_count);
        per_id[id1] <= inc(per_id[id1]);
      end
    end
endmodule

// File: tb/tb_branch_trace_driver.sv
// tb_branch_trace_driver: table vectors, corner sequences and random replays against a trace model
module tb_branch_trace_driver;
  localparam int ID_W = 3, ADDR_W = 8;
  logic clk = 0, reset = 1, load_en = 0, load_outcome = 0, start = 0, miss = 0;
  logic [ADDR_W-1:0] load_addr = '0;
  logic [ID_W-1:0] load_id = '0, stat_sel = '0;
  logic [ADDR_W:0] trace_len = '0;
  logic br_valid, br_outcome, busy, done;
  logic [ID_W-1:0] br_id;
  logic [15:0] total_count, miss_count, stat_miss;
  logic br_valid4, br_outcome4, busy4, done4;
  logic [ID_W-1:0] br_id4;
  logic [3:0] total4, miss4, stat4;
  int checks = 0, errors = 0;
  logic [ID_W-1:0] mid [256];
  logic mo [256];
  logic mp [256];
  int exp_id [8];
  int exp_total, exp_miss;

  typedef struct {
    logic [11:0] ids;
    logic [3:0]  outs;
    logic [3:0]  misses;
    int          sel;
    int          exp_stat;
    int          exp_miss;
  } vec_t;
  vec_t tbl [4];

  branch_trace_driver dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_id(load_id),
    .load_outcome(load_outcome), .trace_len(trace_len), .start(start), .br_valid(br_valid),
    .br_id(br_id), .br_outcome(br_outcome), .miss(miss), .busy(busy), .done(done),
    .total_count(total_count), .miss_count(miss_count), .stat_sel(stat_sel), .stat_miss(stat_miss)
  );
  branch_trace_driver #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr), .load_id(load_id),
    .load_outcome(load_outcome), .trace_len(trace_len), .start(start), .br_valid(br_valid4),
    .br_id(br_id4), .br_outcome(br_outcome4), .miss(miss), .busy(busy4), .done(done4),
    .total_count(total4), .miss_count(miss4), .stat_sel(stat_sel), .stat_miss(stat4)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic int sat(input int x, input int m);
    return x > m ? m : x;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(input int a, input int id, input logic o);
    @(negedge clk);
    load_en = 1; load_addr = a[ADDR_W-1:0]; load_id = id[ID_W-1:0]; load_outcome = o;
    @(negedge clk);
    load_en = 0;
    mid[a] = id[ID_W-1:0];
    mo[a] = o;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1;
    @(negedge clk);
    @(negedge clk); reset = 0;
    chk("rst_br_valid", br_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_total", total_count, 0);
    chk("rst_miss", miss_count, 0);
    chk("rst_stat", stat_miss, 0);
  endtask

  task automatic check_stats();
    for (int s = 0; s < 8; s++) begin
      @(negedge clk); stat_sel = s[ID_W-1:0];
      @(negedge clk);
      chk($sformatf("stat_miss[%0d]", s), stat_miss, exp_id[s]);
      chk($sformatf("stat4[%0d]", s), stat4, sat(exp_id[s], 15));
    end
  endtask

  // Replays n entries; event k's miss is driven in the cycle after the predictor samples it.
  task automatic replay(input int n);
    exp_total = n;
    exp_miss = 0;
    for (int s = 0; s < 8; s++) exp_id[s] = 0;
    for (int k = 0; k < n; k++)
      if (mp[k]) begin
        exp_miss++;
        exp_id[mid[k]]++;
      end
    @(negedge clk); start = 1; trace_len = n[ADDR_W:0];
    @(negedge clk); start = 0;
    for (int c = 0; c <= n + 1; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("br_valid c%0d", c), br_valid, int'(c < n));
      if (c < n) begin
        chk($sformatf("br_id c%0d", c), br_id, mid[c]);
        chk($sformatf("br_outcome c%0d", c), br_outcome, mo[c]);
      end
      chk($sformatf("done c%0d", c), done, n == 0 ? int'(c == 0) : int'(c == n + 1));
      chk($sformatf("busy c%0d", c), busy, int'(n > 0 && c <= n));
      miss = (c >= 1 && c <= n) ? mp[c-1] : 1'($urandom);
    end
    chk("total_count", total_count, exp_total);
    chk("miss_count", miss_count, exp_miss);
    chk("total4", total4, sat(exp_total, 15));
    chk("miss4", miss4, sat(exp_miss, 15));
    check_stats();
  endtask

  initial begin
    tbl[0] = '{12'h000, 4'b1111, 4'b1101, 0, 3, 3};
    tbl[1] = '{{3'd1, 3'd3, 3'd5, 3'd3}, 4'b0101, 4'b0111, 3, 2, 3};
    tbl[2] = '{{3'd1, 3'd3, 3'd5, 3'd3}, 4'b1010, 4'b0111, 5, 1, 3};
    tbl[3] = '{{3'd1, 3'd3, 3'd5, 3'd3}, 4'b0011, 4'b0111, 1, 0, 3};
    repeat (2) @(negedge clk);
    reset = 0;
    chk("init_busy", busy, 0);
    chk("init_total", total_count, 0);
    for (int k = 0; k < 4; k++) load(k, k + 2, k[0]);
    do_reset();
    for (int k = 0; k < 4; k++) mp[k] = 1'(k != 1);
    replay(4);

    for (int t = 0; t < 4; t++) begin
      for (int k = 0; k < 4; k++) begin
        load(k, int'(tbl[t].ids[3*k +: 3]), tbl[t].outs[k]);
        mp[k] = tbl[t].misses[k];
      end
      replay(4);
      @(negedge clk); stat_sel = tbl[t].sel[ID_W-1:0];
      @(negedge clk);
      chk($sformatf("tbl%0d stat_miss", t), stat_miss, tbl[t].exp_stat);
      chk($sformatf("tbl%0d miss_count", t), miss_count, tbl[t].exp_miss);
      chk($sformatf("tbl%0d total_count", t), total_count, 4);
    end

    replay(0);

    for (int k = 0; k < 20; k++) begin
      load(k, int'($urandom_range(0, 7)), 1'($urandom));
      mp[k] = 1'b1;
    end
    replay(20);
    chk("sat total4", total4, 15);
    chk("sat miss4", miss4, 15);
    chk("nosat total", total_count, 20);

    for (int k = 0; k < 8; k++) load(k, 7 - k, k[1]);
    @(negedge clk); start = 1; trace_len = 9'd8;
    @(negedge clk); start = 0;
    start = 1; load_en = 1; load_addr = '0; load_id = ~mid[0]; load_outcome = ~mo[0];
    @(negedge clk); start = 0; load_en = 0;
    chk("run busy", busy, 1);
    chk("run br_id1", br_id, mid[1]);
    @(negedge clk);
    chk("run br_id2", br_id, mid[2]);
    reset = 1;
    @(negedge clk); reset = 0;
    chk("midrst br_valid", br_valid, 0);
    chk("midrst busy", busy, 0);
    chk("midrst total", total_count, 0);
    chk("midrst miss", miss_count, 0);
    for (int k = 0; k < 8; k++) mp[k] = 1'($urandom);
    replay(8);

    for (int r = 0; r < 6; r++) begin
      automatic int n = $urandom_range(1, 40);
      for (int k = 0; k < n; k++) begin
        load(k, int'($urandom_range(0, 7)), 1'($urandom));
        mp[k] = 1'($urandom);
      end
      replay(n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/branch_trace_driver.md
Name: branch_trace_driver

Overview:
- Front end for the team's branch predictors. Replays a stored branch trace of {branchID, outcome} events into a predictor, one event per cycle.
- Collects the predictor's registered miss response and keeps total, miss and per-branchID miss statistics.
- Sits between the testbench or host load port and any predictor with the clk/branchID/outcome/miss interface.

Parameters:
- ID_W, 3, branchID width; 2^ID_W per-ID miss counters.
- DEPTH, 256, trace memory entries.
- ADDR_W, 8, trace address width (log2 DEPTH).
- CNT_W, 16, width of every statistics counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- load_en  input  1  write trace entry (accepted only in IDLE)
- load_addr  input  ADDR_W  trace entry address
- load_id  input  ID_W  branchID to store
- load_outcome  input  1  outcome to store
- trace_len  input  ADDR_W+1  number of entries to replay, 0..DEPTH; sampled on start
- start  input  1  begin replay (accepted only in IDLE)
- br_valid  output  1  br_id/br_outcome hold a live event
- br_id  output  ID_W  branchID to predictor
- br_outcome  output  1  outcome to predictor
- miss  input  1  predictor miss, registered, valid 1 cycle after the event is sampled
- busy  output  1  high in RUN or DRAIN
- done  output  1  one-cycle pulse at end of replay
- total_count  output  CNT_W  events scored
- miss_count  output  CNT_W  events mispredicted
- stat_sel  input  ID_W  per-ID counter select
- stat_miss  output  CNT_W  miss count for stat_sel, registered, 1-cycle latency

Behaviour:
Clock and reset:
- One clock (clk). reset is synchronous and active-high and takes priority over everything.
- On reset: state IDLE; br_valid, br_id, br_outcome, busy, done, stat_miss = 0; all counters = 0; in-flight register cleared.
- Trace memory is not reset; its contents survive reset.

States IDLE, RUN, DRAIN:
- IDLE: load_en writes mem[load_addr] <= {load_id, load_outcome}.
- IDLE, start with trace_len == 0: clear counters and pulse done the next cycle. State stays IDLE.
- IDLE, start with trace_len > 0, edge E0:
  - clear total_count, miss_count and per-ID counters;
  - register len; br <= mem[0]; ptr <= 1; br_valid <= 1; state -> RUN.
- RUN: at each edge, if ptr < len then br <= mem[ptr] and ptr++. Otherwise br_valid <= 0 and state -> DRAIN.
- DRAIN: one cycle, then state -> IDLE with done = 1 for exactly one cycle.
- In RUN and DRAIN, load_en and start are ignored. Trace contents and counters are unchanged by them.

Event timing:
- Entry k is presented during the cycle after edge E_k.
- The predictor samples entry k at E_{k+1}.
- The driver samples miss for entry k at E_{k+2}.
- Last event (N = trace_len): br_valid falls at E_N. Final counts and done are visible after E_{N+1}.
- Start-to-done is N+1 edges after E0.

Scoring pipeline:
- Registers v1/id1 <= br_valid/br_id every edge.
- At each edge with v1 = 1: total_count++. If miss = 1, also miss_count++ and per_id[id1]++.
- When v1 = 0, miss is ignored.
- Every counter saturates at 2^CNT_W - 1; it never wraps.

Other rules:
- busy = (state != IDLE), registered.
- stat_miss <= per_id[stat_sel] every cycle, in every state.
- Reset mid-RUN: br_valid drops the next cycle. The in-flight event is not scored and counts read 0. A later start replays the preserved trace.

Decomposition:
- Package bp_pkg:
  - ID_W default;
  - state encoding (IDLE, RUN, DRAIN);
  - trace entry width ID_W+1 and packing order {id, outcome}.
- One sub-module, branch_trace_mem:
  - DEPTH x (ID_W+1) storage;
  - synchronous write port, asynchronous read port;
  - no reset.
- FSM, pointer, scoring pipeline and saturating counters stay in the top module.

Test Plan:
1. Reset held 2 cycles, then released -> br_valid, busy, done, total_count, miss_count and stat_miss all 0; the replay reads the previously loaded trace unchanged.
2. Load 4 entries (id 0, outcome 1); start with trace_len = 4; bench drives miss pattern 1,0,1,1 aligned per the timing rules -> br_valid high for exactly 4 cycles, done pulses 5 edges after E0, total_count = 4, miss_count = 3.
3. start with trace_len = 0 -> done pulses the next cycle, busy stays 0, all counts 0.
4. Trace ids 3,5,3,1 with misses 1,1,1,0 -> stat_sel = 3 gives stat_miss = 2 one cycle later; stat_sel = 5 gives 1; stat_sel = 1 gives 0; miss_count = 3.
5. CNT_W = 4, 20 entries, miss held 1 -> total_count = 15, miss_count = 15 (saturated, no wrap).
6. During RUN: pulse start and load_en to entry 0 -> both ignored. Then assert reset while entry 2 is presented -> br_valid 0 the next cycle, counts 0, state IDLE. A re-start replays the original entry 0.
